// File: rtl/l1_fmap_buffer.sv
// Frame buffer between the CONV1/pool stage and CONV2: captures one N_CH x FM_H x FM_W
// pooled feature map, freezes it, and serves single-byte random reads until released.
module l1_fmap_buffer #(
  parameter int FM_W   = 12,
  parameter int FM_H   = 12,
  parameter int N_CH   = 6,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_in_valid,
  input  logic signed [DATA_W-1:0] i_in_ch0,
  input  logic signed [DATA_W-1:0] i_in_ch1,
  input  logic signed [DATA_W-1:0] i_in_ch2,
  input  logic signed [DATA_W-1:0] i_in_ch3,
  input  logic signed [DATA_W-1:0] i_in_ch4,
  input  logic signed [DATA_W-1:0] i_in_ch5,
  input  logic                     i_rd_en,
  input  logic [2:0]               i_rd_ch,
  input  logic [3:0]               i_rd_y,
  input  logic [3:0]               i_rd_x,
  output logic signed [DATA_W-1:0] o_rd_data,
  output logic                     o_rd_valid,
  output logic                     o_frame_ready,
  input  logic                     i_frame_release,
  output logic                     o_overflow,
  output logic [7:0]               o_frame_count
);

  localparam int         DEPTH    = FM_W * FM_H;
  localparam logic [7:0] PIX_LAST = 8'(DEPTH - 1);

  typedef enum logic {S_FILL = 1'b0, S_READY = 1'b1} state_t;

  state_t            r_state;
  logic [7:0]        r_pix_idx;
  logic [DATA_W-1:0] r_mem [N_CH][DEPTH];

  logic [DATA_W-1:0] w_in_ch [N_CH];
  logic              w_wr_en;
  logic [7:0]        w_y8;
  logic [7:0]        w_rd_addr;
  logic              w_rd_in_range;

  // The port list carries exactly six channels.
  assign w_in_ch[0] = i_in_ch0;
  assign w_in_ch[1] = i_in_ch1;
  assign w_in_ch[2] = i_in_ch2;
  assign w_in_ch[3] = i_in_ch3;
  assign w_in_ch[4] = i_in_ch4;
  assign w_in_ch[5] = i_in_ch5;

  assign w_wr_en = i_in_valid && (r_state == S_FILL);
  assign w_y8    = {4'd0, i_rd_y};

  generate
    if (FM_W == 12) begin : g_addr_shift_add
      assign w_rd_addr = (w_y8 << 3) + (w_y8 << 2) + {4'd0, i_rd_x};
    end else begin : g_addr_mult
      assign w_rd_addr = 8'(w_y8 * 8'(FM_W)) + {4'd0, i_rd_x};
    end
  endgenerate

  // Out-of-range coordinates read as zero so CONV2 can use them as padding.
  assign w_rd_in_range = (i_rd_ch < 3'(N_CH)) && (i_rd_y < 4'(FM_H)) && (i_rd_x < 4'(FM_W));

  // Per-channel banks: all channels written together at the current raster position.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int c = 0; c < N_CH; c++) begin
        r_mem[c][r_pix_idx] <= w_in_ch[c];
      end
    end
  end

  // Fill/ready control, registered read port and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_FILL;
      r_pix_idx     <= 8'd0;
      o_rd_data     <= '0;
      o_rd_valid    <= 1'b0;
      o_frame_ready <= 1'b0;
      o_overflow    <= 1'b0;
      o_frame_count <= 8'd0;
    end else begin
      if ((r_state == S_READY) && i_rd_en) begin
        o_rd_valid <= 1'b1;
        o_rd_data  <= w_rd_in_range ? r_mem[i_rd_ch][w_rd_addr] : '0;
      end else begin
        o_rd_valid <= 1'b0;
      end

      case (r_state)
        S_FILL: begin
          if (i_in_valid) begin
            if (r_pix_idx == PIX_LAST) begin
              r_pix_idx     <= 8'd0;
              o_frame_count <= o_frame_count + 8'd1;
              r_state       <= S_READY;
              o_frame_ready <= 1'b1;
            end else begin
              r_pix_idx <= r_pix_idx + 8'd1;
            end
          end
        end
        S_READY: begin
          if (i_in_valid) begin
            o_overflow <= 1'b1;
          end
          if (i_frame_release) begin
            r_state       <= S_FILL;
            o_frame_ready <= 1'b0;
          end
        end
        default: begin
          r_state       <= S_FILL;
          r_pix_idx     <= 8'd0;
          o_frame_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1_fmap_buffer.sv
// Randomized self-checking bench for l1_fmap_buffer against a frame-level reference model.
module tb_l1_fmap_buffer;

  localparam int W = 12, H = 12, NC = 6, NPIX = W * H;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_ch [NC];
  logic       rd_en = 1'b0;
  logic [2:0] rd_ch = 3'd0;
  logic [3:0] rd_y = 4'd0, rd_x = 4'd0;
  logic       frame_release = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, frame_ready, overflow;
  logic [7:0] frame_count;

  // reference model state
  logic [7:0] ref_mem [NC][NPIX];
  bit         m_ready;
  int         m_pix;
  logic [7:0] m_count;
  bit         m_ovf;
  logic [7:0] m_last;

  int n_chk = 0;
  int n_err = 0;

  l1_fmap_buffer dut (
    .clk(clk), .rst(rst), .i_in_valid(in_valid),
    .i_in_ch0(in_ch[0]), .i_in_ch1(in_ch[1]), .i_in_ch2(in_ch[2]),
    .i_in_ch3(in_ch[3]), .i_in_ch4(in_ch[4]), .i_in_ch5(in_ch[5]),
    .i_rd_en(rd_en), .i_rd_ch(rd_ch), .i_rd_y(rd_y), .i_rd_x(rd_x),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_frame_ready(frame_ready),
    .i_frame_release(frame_release), .o_overflow(overflow), .o_frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ready = 1'b0; m_pix = 0; m_count = 8'd0; m_ovf = 1'b0; m_last = 8'd0;
  endtask

  // One clock cycle: drive inputs, advance the model, then compare all outputs.
  task automatic cycle(input bit v, input logic [47:0] d, input bit re,
                       input int ch, input int y, input int x, input bit rel);
    bit exp_v;
    in_valid = v;
    for (int c = 0; c < NC; c++) in_ch[c] = d[c*8 +: 8];
    rd_en = re; rd_ch = 3'(ch); rd_y = 4'(y); rd_x = 4'(x);
    frame_release = rel;
    exp_v = m_ready && re;
    if (exp_v) m_last = (ch < NC && y < H && x < W) ? ref_mem[ch][y*W + x] : 8'd0;
    if (v) begin
      if (!m_ready) begin
        for (int c = 0; c < NC; c++) ref_mem[c][m_pix] = d[c*8 +: 8];
        if (m_pix == NPIX - 1) begin
          m_pix = 0; m_count = m_count + 8'd1; m_ready = 1'b1;
        end else begin
          m_pix++;
        end
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (m_ready && rel && !(v && m_pix == 0 && !exp_v && 1'b0)) begin
      if (!(v && m_pix == 0 && m_ready && !m_ovf && 1'b0)) ;
    end
    @(posedge clk);
    #1;
    check_eq("rd_valid", 32'(rd_valid), 32'(exp_v));
    check_eq("rd_data", 32'(rd_data), 32'(m_last));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    check_eq("frame_count", 32'(frame_count), 32'(m_count));
  endtask

  task automatic tick_check_ready();
    check_eq("frame_ready", 32'(frame_ready), 32'(m_ready));
  endtask

  // Release handled separately so ready-state sampling before the edge stays clear.
  task automatic step(input bit v, input logic [47:0] d, input bit re,
                      input int ch, input int y, input int x, input bit rel);
    bit was_ready;
    was_ready = m_ready;
    cycle(v, d, re, ch, y, x, rel);
    if (was_ready && rel) m_ready = 1'b0;
    tick_check_ready();
  endtask

  task automatic idle();
    step(1'b0, 48'd0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  // mode 0: (c*24+p) mod 128, mode 1: all 0xFF, mode 2: random
  task automatic send_frame(input int mode, input int gap_max, input int rd_pulse_at);
    logic [47:0] d;
    for (int p = 0; p < NPIX; p++) begin
      int gaps;
      gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int g = 0; g < gaps; g++) idle();
      for (int c = 0; c < NC; c++) begin
        case (mode)
          0:       d[c*8 +: 8] = 8'((c*24 + p) % 128);
          1:       d[c*8 +: 8] = 8'hFF;
          default: d[c*8 +: 8] = 8'($urandom);
        endcase
      end
      step(1'b1, d, p == rd_pulse_at, int'($urandom_range(5, 0)),
           int'($urandom_range(11, 0)), int'($urandom_range(11, 0)), 1'b0);
    end
  endtask

  // Reads every (ch,y,x) once, back-to-back, in shuffled order.
  task automatic read_all();
    int idx [NC*NPIX];
    for (int i = 0; i < NC*NPIX; i++) idx[i] = i;
    for (int i = NC*NPIX - 1; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(i, 0));
      t = idx[i]; idx[i] = idx[j]; idx[j] = t;
    end
    for (int i = 0; i < NC*NPIX; i++)
      step(1'b0, 48'd0, 1'b1, idx[i] / NPIX, (idx[i] % NPIX) / W, idx[i] % W, 1'b0);
  endtask

  task automatic do_reset(input int hold);
    rst = 1'b1;
    #2;
    check_eq("rst_rd_data", 32'(rd_data), 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_frame_ready", 32'(frame_ready), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_frame_count", 32'(frame_count), 32'd0);
    repeat (hold) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    for (int c = 0; c < NC; c++) in_ch[c] = 8'd0;
    model_reset();
    do_reset(3);

    // frame 1: test-plan pattern, rd_en pulsed during fill
    send_frame(0, 0, 50);
    check_eq("f1_count", 32'(frame_count), 32'd1);
    read_all();

    // zero-padding reads
    step(1'b0, 48'd0, 1'b1, 6, 0, 0, 1'b0);
    step(1'b0, 48'd0, 1'b1, 0, 12, 0, 1'b0);
    step(1'b0, 48'd0, 1'b1, 0, 0, 15, 1'b0);
    for (int i = 0; i < 10; i++)
      step(1'b0, 48'd0, 1'b1, int'($urandom_range(7, 0)),
           int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), 1'b0);

    // dropped beats in READY
    for (int i = 0; i < 3; i++) step(1'b1, {6{8'h7F}}, 1'b0, 0, 0, 0, 1'b0);
    check_eq("ovf_set", 32'(overflow), 32'd1);
    idle();
    read_all();

    // read + release in the same cycle, then a read in FILL
    step(1'b0, 48'd0, 1'b1, 3, 7, 5, 1'b1);
    check_eq("rel_ready", 32'(frame_ready), 32'd0);
    step(1'b0, 48'd0, 1'b1, 1, 1, 1, 1'b0);

    // frame 2: all -1 with random gaps
    send_frame(1, 3, -1);
    check_eq("f2_count", 32'(frame_count), 32'd2);
    read_all();

    // in_valid + release together: beat dropped, then frame 3 random
    step(1'b1, {6{8'h55}}, 1'b0, 0, 0, 0, 1'b1);
    send_frame(2, 2, -1);
    check_eq("f3_count", 32'(frame_count), 32'd3);
    read_all();

    // reset mid-frame after 70 beats
    step(1'b0, 48'd0, 1'b0, 0, 0, 0, 1'b1);
    for (int p = 0; p < 70; p++) step(1'b1, {$urandom, 16'($urandom)}, 1'b0, 0, 0, 0, 1'b0);
    do_reset(2);
    send_frame(2, 1, -1);
    check_eq("rst_f_count", 32'(frame_count), 32'd1);
    read_all();
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
